proyecto1_input_stage: RTL and testbench
========================================

# proyecto1_input_stage

Upstream conditioning stage for the Proyecto1 controller. It synchronizes and debounces the raw field inputs W, A, ES, D and STL, and contains the phase timer that produces the controller's T (timeout) input. It takes load and duration-select commands back from the controller, so the controller itself contains no counters and no asynchronous input handling.

## Interface
- DEB_CYCLES, 4: number of consecutive stable synchronized samples needed before a debounced output changes (legal range 1..15).
- T_SHORT, 3: duration in cycles for tmr_sel=0.
- T_MED, 6: duration in cycles for tmr_sel=1.
- T_LONG, 10: duration in cycles for tmr_sel=2 and tmr_sel=3.
- CNT_W, 8: timer counter width; every duration must be below 2^CNT_W.

Ports:
- clck  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_raw, a_raw, es_raw, d_raw, stl_raw  in  1 each  raw asynchronous sensor and button levels.
- tmr_load  in  1  one-cycle pulse from the controller that starts or restarts the timer.
- tmr_sel  in  2  duration select, sampled only while tmr_load=1.
- stl_clr  in  1  clears the latched STL request (used only with the macro defined).
- W, A, ES, D, STL  out  1 each  debounced levels delivered to the controller.
- T  out  1  timer-expired level.
- busy  out  1  high while the timer is counting.

## Operation
- **Reset state (rst=0):**
  - All outputs are 0.
  - Synchronizer flops, debounce counters and the timer counter are 0.
- **Input conditioning, per input:**
  - A 2-flop synchronizer feeds a debounce sub-block.
  - When the synchronized value equals the current output, the stable counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES, the output takes the new value on that same edge and the counter clears.
  - A glitch shorter than DEB_CYCLES synchronized samples never reaches the output.
- **Timer, two states: IDLE and RUN:**
  - IDLE, tmr_load=1: the counter loads dur−1, where dur is selected by tmr_sel. The block enters RUN, clears T and sets busy.
  - RUN: the counter decrements each cycle. On the edge where it is 0, the block returns to IDLE, T is set and busy is cleared.
  - RUN, tmr_load=1: the counter reloads with the new dur and T stays 0. Load has priority over expiry on the same edge.
  - T stays high in IDLE until the next tmr_load.
  - Any dur of 0 is treated as 1.

## Timing
- Raw to debounced latency is 2 + DEB_CYCLES rising edges after the raw level settles.
- Timer latency:
  - tmr_load is sampled high at edge n.
  - T rises at edge n+dur, for example n+3 with T_SHORT.
  - busy is high from edge n to n+dur.
- Reset asserted mid-count forces IDLE with T=0 immediately, without waiting for a clock edge.
- After reset is released, the outputs hold 0 until the debounce completes. An input held at 1 through reset therefore appears at edge 2+DEB_CYCLES.
- Simultaneous tmr_load and stl_clr are independent and both take effect.

## Configuration
- **PROY1_STL_LATCH_EN defined:** STL is a sticky request.
  - It sets on the debounced rising edge of stl_raw and holds until stl_clr is sampled high.
  - If a set and stl_clr occur in the same cycle, set wins.
- **PROY1_STL_LATCH_EN undefined:** STL is the plain debounced level and stl_clr is ignored.

## Structure
- **proyecto1_pkg** holds:
  - the tmr_sel encodings TSEL_SHORT=0, TSEL_MED=1, TSEL_LONG=2;
  - the timer state encodings IDLE and RUN.
- **proyecto1_debounce** is a sub-module:
  - It contains the synchronizer and stable counter and is parameterized by DEB_CYCLES.
  - It is instantiated five times.
- The timer and the STL latch live in the top level.

## Test plan
- **Reset:** assert rst=0 mid-operation with T=1 and w_raw=1 → every output is 0 immediately; W=1 at the 6th edge after release (DEB_CYCLES=4).
- **Glitch rejection:** a_raw high for 3 cycles → A stays 0. a_raw high for 8 cycles → A=1 at edge 6 after the rise.
- **Timer short and long:** tmr_load with sel=0 at edge 10 → T=1 at edge 13 and busy 0 from edge 13. Sel=3 → T at load+10.
- **Restart:** load sel=2 at edge 0, then load sel=0 at edge 5 → T stays 0 until edge 8, then 1. T stays high until the next load.
- **STL latch (macro on):** stl_raw pulse of 8 cycles → STL=1 held after the raw input drops. stl_clr → 0 next edge. stl_clr coincident with a new set → STL stays 1.
- **Macro off:** same stimulus → STL follows the debounced level and stl_clr has no effect.

Source files
------------

// File: rtl/proyecto1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proyecto1_pkg
// Brief    : Shared encodings for the Proyecto1 input stage (timer select
//            codes, timer state machine states, timer load helper).
// Revision : 1.0 - initial release
// ============================================================================
package proyecto1_pkg;

    localparam logic [1:0] TSEL_SHORT = 2'd0;
    localparam logic [1:0] TSEL_MED   = 2'd1;
    localparam logic [1:0] TSEL_LONG  = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    // A zero duration behaves as a single cycle, so it loads the same value as 1.
    function automatic int load_value(input int dur);
        return (dur <= 1) ? 0 : dur - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proyecto1_debounce.sv
`default_nettype none
// ============================================================================
// Module   : proyecto1_debounce
// Brief    : Two-flop synchronizer followed by a stable-sample counter that
//            commits a new level after DEB_CYCLES consecutive differing samples.
// Revision : 1.0 - initial release
// ============================================================================
module proyecto1_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [3:0] c_deb = 4'(DEB_CYCLES);

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       w_diff;
    logic       w_flip;

    assign w_diff = (r_sync2 != r_level);
    assign w_flip = w_diff && ((r_cnt + 4'd1) == c_deb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= 4'd0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= 4'd0;
            end else if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_level = r_level;
    // High in the cycle before the edge that commits a 0->1 change.
    assign o_rise  = w_flip & r_sync2;

endmodule
`default_nettype wire

// File: rtl/proyecto1_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : proyecto1_input_stage
// Brief    : Debounces the W/A/ES/D/STL field inputs and runs the phase timer
//            that feeds T back to the controller. Define PROY1_STL_LATCH_EN to
//            make STL a sticky request cleared by stl_clr.
// Revision : 1.0 - initial release
// ============================================================================
module proyecto1_input_stage
    import proyecto1_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int T_SHORT    = 3,
    parameter int T_MED      = 6,
    parameter int T_LONG     = 10,
    parameter int CNT_W      = 8
) (
    input  logic       clck,
    input  logic       rst,
    input  logic       w_raw,
    input  logic       a_raw,
    input  logic       es_raw,
    input  logic       d_raw,
    input  logic       stl_raw,
    input  logic       tmr_load,
    input  logic [1:0] tmr_sel,
    input  logic       stl_clr,
    output logic       W,
    output logic       A,
    output logic       ES,
    output logic       D,
    output logic       STL,
    output logic       T,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_ld_short = CNT_W'(load_value(T_SHORT));
    localparam logic [CNT_W-1:0] c_ld_med   = CNT_W'(load_value(T_MED));
    localparam logic [CNT_W-1:0] c_ld_long  = CNT_W'(load_value(T_LONG));

    logic [4:0] w_raw_vec;
    logic [4:0] w_deb;
    logic [4:0] w_rise;

    assign w_raw_vec = {stl_raw, d_raw, es_raw, a_raw, w_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_deb
            proyecto1_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clck),
                .rst_n  (rst),
                .i_raw  (w_raw_vec[gi]),
                .o_level(w_deb[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign W  = w_deb[0];
    assign A  = w_deb[1];
    assign ES = w_deb[2];
    assign D  = w_deb[3];

    // ---------------------------------------------------------------- timer
    tmr_state_t       r_state;
    tmr_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ld_val;
    logic             r_t;
    logic             w_t_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    always_comb begin
        case (tmr_sel)
            TSEL_SHORT: w_ld_val = c_ld_short;
            TSEL_MED:   w_ld_val = c_ld_med;
            default:    w_ld_val = c_ld_long;
        endcase
    end

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_t     <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_t     <= w_t_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // A load wins over expiry in RUN, so restarting never flashes T.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_t_nxt     = r_t;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (tmr_load) begin
                    w_cnt_nxt   = w_ld_val;
                    w_state_nxt = RUN;
                    w_t_nxt     = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (tmr_load) begin
                    w_cnt_nxt  = w_ld_val;
                    w_t_nxt    = 1'b0;
                    w_busy_nxt = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_t_nxt     = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign T    = r_t;
    assign busy = r_busy;

    // ------------------------------------------------------------ STL path
`ifdef PROY1_STL_LATCH_EN
    logic r_stl;
    logic w_unused;

    // A new set in the same cycle as stl_clr keeps the request alive.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_stl <= 1'b0;
        end else if (w_rise[4]) begin
            r_stl <= 1'b1;
        end else if (stl_clr) begin
            r_stl <= 1'b0;
        end
    end

    assign STL      = r_stl;
    assign w_unused = &{1'b0, w_rise[3:0]};
`else
    logic w_unused;

    assign STL      = w_deb[4];
    assign w_unused = &{1'b0, stl_clr, w_rise};
`endif

endmodule
`default_nettype wire

// File: tb/tb_proyecto1_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_proyecto1_input_stage
// Brief    : Directed plus randomized bench for proyecto1_input_stage with a
//            behavioural model of debounce, timer and STL request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proyecto1_input_stage;

    localparam int DEB = 4;

    logic       clck = 1'b0;
    logic       rst  = 1'b0;
    logic       w_raw = 1'b0, a_raw = 1'b0, es_raw = 1'b0, d_raw = 1'b0, stl_raw = 1'b0;
    logic       tmr_load = 1'b0;
    logic [1:0] tmr_sel  = 2'd0;
    logic       stl_clr  = 1'b0;
    logic       W, A, ES, D, STL, T, busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: raw values seen 1 and 2 edges ago, committed
    // levels, length of the current run of samples differing from the level.
    logic [4:0] m_p1, m_p2, m_out;
    int         m_run [5];
    int         m_edge = 0;
    int         m_exp  = 0;
    bit         m_armed;
    logic       m_stl;

    proyecto1_input_stage dut (
        .clck    (clck),
        .rst     (rst),
        .w_raw   (w_raw),
        .a_raw   (a_raw),
        .es_raw  (es_raw),
        .d_raw   (d_raw),
        .stl_raw (stl_raw),
        .tmr_load(tmr_load),
        .tmr_sel (tmr_sel),
        .stl_clr (stl_clr),
        .W       (W),
        .A       (A),
        .ES      (ES),
        .D       (D),
        .STL     (STL),
        .T       (T),
        .busy    (busy)
    );

    always #5 clck = ~clck;

    function automatic int dur_of(input logic [1:0] s);
        case (s)
            2'd0:    return 3;
            2'd1:    return 6;
            default: return 10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":W"},    W,    m_out[0]);
        chk({tag, ":A"},    A,    m_out[1]);
        chk({tag, ":ES"},   ES,   m_out[2]);
        chk({tag, ":D"},    D,    m_out[3]);
        chk({tag, ":STL"},  STL,  m_stl);
        chk({tag, ":T"},    T,    logic'(m_armed && (m_edge >= m_exp)));
        chk({tag, ":busy"}, busy, logic'(m_armed && (m_edge < m_exp)));
    endtask

    task automatic model_reset();
        m_p1    = '0;
        m_p2    = '0;
        m_out   = '0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        m_armed = 1'b0;
        m_stl   = 1'b0;
    endtask

    task automatic model_edge();
        logic [4:0] raw;
        bit         rise;
        raw  = {stl_raw, d_raw, es_raw, a_raw, w_raw};
        rise = 1'b0;
        m_edge++;
        for (int i = 0; i < 5; i++) begin
            if (m_p2[i] != m_out[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_out[i] = m_p2[i];
                    m_run[i] = 0;
                    if (i == 4 && m_out[4]) rise = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = raw;
        if (tmr_load) begin
            m_armed = 1'b1;
            m_exp   = m_edge + dur_of(tmr_sel);
        end
`ifdef PROY1_STL_LATCH_EN
        if (rise) m_stl = 1'b1;
        else if (stl_clr) m_stl = 1'b0;
`else
        m_stl = m_out[4];
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clck);
        if (rst) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic load(input logic [1:0] sel, input string tag);
        tmr_load = 1'b1;
        tmr_sel  = sel;
        step(tag);
        tmr_load = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset0");
        steps(2, "reset");

        // w held high through reset release
        w_raw = 1'b1;
        rst   = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step("rel");
            chk("w_latency", W, logic'(k >= 6));
        end

        // short glitch on a_raw is rejected
        a_raw = 1'b1;
        steps(3, "glitch");
        a_raw = 1'b0;
        steps(8, "glitch_lo");
        chk("a_glitch", A, 1'b0);

        a_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step("a_long");
            chk("a_latency", A, logic'(k >= 6));
        end
        a_raw = 1'b0;
        steps(8, "a_fall");

        // timer short
        load(2'd0, "ld_short");
        for (int k = 1; k <= 4; k++) begin
            step("t_short");
            chk("t_short_T", T, logic'(k >= 3));
            chk("t_short_busy", busy, logic'(k < 3));
        end

        // timer with sel=3 uses the long duration
        load(2'd3, "ld_sel3");
        for (int k = 1; k <= 11; k++) begin
            step("t_sel3");
            chk("t_sel3_T", T, logic'(k >= 10));
        end

        // restart: long at edge 0, short at edge 5
        load(2'd2, "ld_restart0");
        steps(4, "restart");
        load(2'd0, "ld_restart5");
        chk("restart_T_e5", T, 1'b0);
        for (int k = 6; k <= 10; k++) begin
            step("restart_run");
            chk("restart_T", T, logic'(k >= 8));
        end
        steps(5, "t_hold");
        chk("t_hold", T, 1'b1);

        // STL pulse, clear, and clear coincident with a new set
        stl_raw = 1'b1;
        steps(8, "stl_pulse");
        stl_raw = 1'b0;
        steps(10, "stl_after");
`ifdef PROY1_STL_LATCH_EN
        chk("stl_sticky", STL, 1'b1);
`else
        chk("stl_level", STL, 1'b0);
`endif
        stl_clr = 1'b1;
        step("stl_clr");
        stl_clr = 1'b0;
        chk("stl_cleared", STL, 1'b0);
        stl_raw = 1'b1;
        stl_clr = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step("stl_coinc");
            if (k == 6) chk("stl_set_wins", STL, 1'b1);
        end
        stl_clr = 1'b0;
        stl_raw = 1'b0;
        steps(8, "stl_coinc_end");

        // asynchronous reset mid-operation with T=1 and W=1
        w_raw = 1'b1;
        load(2'd0, "pre_rst_ld");
        steps(4, "pre_rst");
        chk("pre_rst_T", T, 1'b1);
        chk("pre_rst_W", W, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        steps(2, "in_rst");
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step("rel2");
            chk("w_latency2", W, logic'(k >= 6));
        end

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) w_raw   = ~w_raw;
            if ($urandom_range(0, 7) == 0) a_raw   = ~a_raw;
            if ($urandom_range(0, 7) == 0) es_raw  = ~es_raw;
            if ($urandom_range(0, 7) == 0) d_raw   = ~d_raw;
            if ($urandom_range(0, 7) == 0) stl_raw = ~stl_raw;
            tmr_load = ($urandom_range(0, 9) == 0);
            tmr_sel  = 2'($urandom_range(0, 3));
            stl_clr  = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        tmr_load = 1'b0;
        stl_clr  = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
